// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: autonomous command sequencer for the conv1d CFU.
// Preloads the input ring buffer, then per output position issues start/poll/read,
// streams the quantized result out, refills one column and advances the ring origin.
// While idle the CFU port is handed straight through to the host.
module conv1d_sequencer #(
    parameter int unsigned KERNEL_LENGTH = 8,
    parameter int unsigned MAX_DEPTH     = 128,
    parameter int unsigned POLL_TIMEOUT  = 4096,
    parameter int unsigned CMD_NOP       = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg_depth,
    input  logic [15:0] cfg_positions,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        host_en,
    input  logic [6:0]  host_cmd,
    input  logic [31:0] host_inp0,
    input  logic [31:0] host_inp1,
    output logic        host_grant,
    output logic [31:0] host_ret,
    output logic        cfu_en,
    output logic [6:0]  cfu_cmd,
    output logic [31:0] cfu_inp0,
    output logic [31:0] cfu_inp1,
    input  logic [31:0] cfu_ret
);

    localparam logic [6:0] CmdWrite    = 7'd1;
    localparam logic [6:0] CmdSetDepth = 7'd5;
    localparam logic [6:0] CmdStart    = 7'd6;
    localparam logic [6:0] CmdRead     = 7'd7;
    localparam logic [6:0] CmdSetX     = 7'd8;
    localparam logic [6:0] CmdNop      = 7'(CMD_NOP);
    localparam int unsigned XW = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StReject,
        StCfgDepth,
        StCfgX,
        StPreload,
        StStart,
        StPoll,
        StRead,
        StCapture,
        StEmit,
        StRefill
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      depth_q, depth_d;
    logic [15:0]     positions_q, positions_d;
    logic [XW-1:0]   start_x_q, start_x_d;
    logic [15:0]     pos_cnt_q, pos_cnt_d;
    logic [9:0]      word_cnt_q, word_cnt_d;
    logic [31:0]     poll_cnt_q, poll_cnt_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            eng_en;
    logic [6:0]      eng_cmd;
    logic [31:0]     eng_inp0;
    logic [31:0]     eng_inp1;

    logic            cfg_bad;
    logic            accept;
    logic            preload_last;
    logic            refill_last;
    logic [15:0]     pos_cnt_inc;
    logic [XW-1:0]   start_x_next;
    logic [31:0]     word_offset;
    logic [31:0]     refill_addr;

    assign cfg_bad = (cfg_depth == 8'd0) || (cfg_depth[1:0] != 2'b00) ||
                     (32'(cfg_depth) > MAX_DEPTH) || (cfg_positions == 16'd0);

    assign accept       = in_valid & in_ready;
    assign preload_last = (word_cnt_q == (10'({depth_q, 1'b0}) - 10'd1));
    assign refill_last  = (word_cnt_q == (10'(depth_q >> 2) - 10'd1));
    assign pos_cnt_inc  = pos_cnt_q + 16'd1;
    assign start_x_next = (start_x_q == XW'(KERNEL_LENGTH - 1)) ? '0 : start_x_q + 1'b1;
    assign word_offset  = {20'b0, word_cnt_q, 2'b00};
    // Refill overwrites the oldest column, which sits at the current ring origin.
    assign refill_addr  = 32'(start_x_q) * 32'(depth_q) + word_offset;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: run config, counters, output holding register, status.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q     <= '0;
            positions_q <= '0;
            start_x_q   <= '0;
            pos_cnt_q   <= '0;
            word_cnt_q  <= '0;
            poll_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            depth_q     <= depth_d;
            positions_q <= positions_d;
            start_x_q   <= start_x_d;
            pos_cnt_q   <= pos_cnt_d;
            word_cnt_q  <= word_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Next-state logic and the engine's per-state CFU command.
    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        positions_d = positions_q;
        start_x_d   = start_x_q;
        pos_cnt_d   = pos_cnt_q;
        word_cnt_d  = word_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;
        eng_en      = 1'b1;
        eng_cmd     = CmdNop;
        eng_inp0    = '0;
        eng_inp1    = '0;
        in_ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                eng_en = 1'b0;
                if (start) begin
                    depth_d     = cfg_depth;
                    positions_d = cfg_positions;
                    err_d       = 1'b0;
                    err_code_d  = 2'd0;
                    start_x_d   = '0;
                    pos_cnt_d   = '0;
                    word_cnt_d  = '0;
                    state_d     = cfg_bad ? StReject : StCfgDepth;
                end
            end
            StReject: begin
                // A rejected config never touches the CFU.
                eng_en     = 1'b0;
                err_d      = 1'b1;
                err_code_d = 2'd1;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            StCfgDepth: begin
                eng_cmd  = CmdSetDepth;
                eng_inp1 = 32'(depth_q);
                state_d  = StCfgX;
            end
            StCfgX: begin
                eng_cmd  = CmdSetX;
                eng_inp1 = 32'(start_x_q);
                // Only the very first position needs the full ring preloaded.
                state_d  = (pos_cnt_q == 16'd0) ? StPreload : StStart;
            end
            StPreload: begin
                in_ready = 1'b1;
                if (accept) begin
                    eng_cmd  = CmdWrite;
                    eng_inp0 = word_offset;
                    eng_inp1 = in_data;
                    if (preload_last) begin
                        word_cnt_d = '0;
                        state_d    = StStart;
                    end else begin
                        word_cnt_d = word_cnt_q + 10'd1;
                    end
                end
            end
            StStart: begin
                eng_cmd    = CmdStart;
                poll_cnt_d = '0;
                state_d    = StPoll;
            end
            StPoll: begin
                // First poll cycle still shows the ret of the start command; skip it.
                if ((poll_cnt_q != 32'd0) && cfu_ret[0]) begin
                    state_d = StRead;
                end else if (poll_cnt_q == 32'(POLL_TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end else begin
                    poll_cnt_d = poll_cnt_q + 32'd1;
                end
            end
            StRead: begin
                eng_cmd = CmdRead;
                state_d = StCapture;
            end
            StCapture: begin
                out_data_d  = cfu_ret;
                out_valid_d = 1'b1;
                state_d     = StEmit;
            end
            StEmit: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pos_cnt_d   = pos_cnt_inc;
                    if (pos_cnt_inc == positions_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StRefill;
                    end
                end
            end
            StRefill: begin
                in_ready = 1'b1;
                if (accept) begin
                    eng_cmd  = CmdWrite;
                    eng_inp0 = refill_addr;
                    eng_inp1 = in_data;
                    if (refill_last) begin
                        word_cnt_d = '0;
                        start_x_d  = start_x_next;
                        state_d    = StCfgX;
                    end else begin
                        word_cnt_d = word_cnt_q + 10'd1;
                    end
                end
            end
            default: begin
                eng_en  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign host_grant = ~busy;
    assign host_ret   = cfu_ret;

    // Host owns the port whenever the engine is idle; host requests are dropped otherwise.
    always_comb begin
        if (busy) begin
            cfu_en   = eng_en;
            cfu_cmd  = eng_cmd;
            cfu_inp0 = eng_inp0;
            cfu_inp1 = eng_inp1;
        end else begin
            cfu_en   = host_en;
            cfu_cmd  = host_cmd;
            cfu_inp0 = host_inp0;
            cfu_inp1 = host_inp1;
        end
    end

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Bench for conv1d_sequencer: a small conv1d stand-in answers the CFU port, a stream
// source feeds input words, and each run's commands and outputs are compared against
// expectations computed from the input stream.
module tb_conv1d_sequencer;

    localparam int unsigned PollTimeout = 16;
    localparam int          StubLat     = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_depth;
    logic [15:0] cfg_positions;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        host_en;
    logic [6:0]  host_cmd;
    logic [31:0] host_inp0, host_inp1;
    logic        host_grant;
    logic [31:0] host_ret;
    logic        cfu_en;
    logic [6:0]  cfu_cmd;
    logic [31:0] cfu_inp0, cfu_inp1;
    logic [31:0] cfu_ret;

    always #5 clk = ~clk;

    conv1d_sequencer #(
        .KERNEL_LENGTH(8),
        .MAX_DEPTH    (128),
        .POLL_TIMEOUT (PollTimeout),
        .CMD_NOP      (9)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_depth    (cfg_depth),
        .cfg_positions(cfg_positions),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .host_en      (host_en),
        .host_cmd     (host_cmd),
        .host_inp0    (host_inp0),
        .host_inp1    (host_inp1),
        .host_grant   (host_grant),
        .host_ret     (host_ret),
        .cfu_en       (cfu_en),
        .cfu_cmd      (cfu_cmd),
        .cfu_inp0     (cfu_inp0),
        .cfu_inp1     (cfu_inp1),
        .cfu_ret      (cfu_ret)
    );

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // ---------------------------------------------------------------- stream data
    function automatic logic [7:0] sbyte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    function automatic logic [31:0] sword(input int w);
        return {sbyte(4 * w + 3), sbyte(4 * w + 2), sbyte(4 * w + 1), sbyte(4 * w)};
    endfunction

    // Output p covers stream columns p..p+7, tap weight c+1 on column p+c.
    function automatic logic [31:0] model(input int depth, input int p);
        int acc;
        int b;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            for (int d = 0; d < depth; d++) begin
                b = int'($signed(sbyte((p + c) * depth + d)));
                acc += (c + 1) * b;
            end
        end
        return 32'(acc);
    endfunction

    // ---------------------------------------------------------------- conv1d stand-in
    logic [7:0]  cbuf [0:1023];
    logic [31:0] st_depth = 32'd0;
    logic [31:0] st_sx    = 32'd0;
    logic [31:0] st_pend  = 32'd0;
    logic [31:0] st_res   = 32'd0;
    logic [31:0] stub_ret = 32'd0;
    logic        st_ready = 1'b0;
    int          st_cnt   = 0;
    bit          stub_never = 1'b0;

    assign cfu_ret = stub_ret;

    function automatic logic [31:0] stub_compute();
        int acc;
        int slot;
        int b;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            slot = (int'(st_sx) + c) % 8;
            for (int d = 0; d < int'(st_depth); d++) begin
                b = int'($signed(cbuf[slot * int'(st_depth) + d]));
                acc += (c + 1) * b;
            end
        end
        return 32'(acc);
    endfunction

    always @(posedge clk) begin
        if (st_cnt > 0) begin
            st_cnt <= st_cnt - 1;
            if (st_cnt == 1) begin
                st_ready <= 1'b1;
                st_res   <= st_pend;
            end
        end
        if (cfu_en) begin
            case (cfu_cmd)
                7'd1: begin
                    for (int b = 0; b < 4; b++) cbuf[10'(cfu_inp0 + 32'(b))] <= cfu_inp1[8*b +: 8];
                    stub_ret <= 32'd0;
                end
                7'd5: begin st_depth <= cfu_inp1; stub_ret <= 32'd0; end
                7'd8: begin st_sx <= cfu_inp1; stub_ret <= 32'd0; end
                7'd6: begin
                    st_pend  <= stub_compute();
                    st_ready <= 1'b0;
                    st_cnt   <= stub_never ? 0 : StubLat;
                    stub_ret <= 32'd1;
                end
                7'd7:    stub_ret <= st_res;
                default: stub_ret <= {31'b0, st_ready};
            endcase
        end
    end

    // ---------------------------------------------------------------- monitor / stream source
    typedef struct packed {
        logic [6:0]  cmd;
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    cmd_t        cmd_log[$];
    logic [31:0] out_got[$];
    int done_cnt   = 0;
    int busy_cnt   = 0;
    int eng_en_cnt = 0;
    int poll_nops  = 0;
    int src_idx    = 0;
    int src_base   = 0;
    int src_end    = 0;
    bit src_en     = 1'b1;

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (busy && cfu_en) begin
            eng_en_cnt++;
            if (cfu_cmd == 7'd9) poll_nops++;
            else begin
                cmd_log.push_back(cmd_t'{cmd: cfu_cmd, a: cfu_inp0, d: cfu_inp1});
                if (cfu_cmd == 7'd6) poll_nops = 0;
            end
        end
        if (out_valid && out_ready) out_got.push_back(out_data);
        if (in_valid && in_ready) src_idx++;
        #1;
        in_valid = src_en && (src_idx < src_end);
        in_data  = in_valid ? sword(src_idx - src_base) : 32'h0;
    end

    function automatic int count6(input int from);
        int n;
        n = 0;
        for (int i = from; i < cmd_log.size(); i++) if (cmd_log[i].cmd == 7'd6) n++;
        return n;
    endfunction

    // ---------------------------------------------------------------- one full run
    task automatic run(input int depth, input int positions, input bit hold);
        int   words, log_base, out_base, done_base, cyc, viol, c6, errs, sx, wi, n;
        logic [31:0] held;
        cmd_t exp_q[$];
        words     = 2 * depth + (positions - 1) * (depth / 4);
        log_base  = cmd_log.size();
        out_base  = out_got.size();
        done_base = done_cnt;
        src_base  = src_idx;
        src_end   = src_idx + words;
        if (hold) out_ready = 1'b0;
        cfg_depth     = 8'(depth);
        cfg_positions = 16'(positions);
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (hold) begin
            cyc = 0;
            while (!out_valid && cyc < 2000) begin @(negedge clk); cyc++; end
            check("bp_reach_emit", 32'(out_valid), 32'd1);
            held = out_data;
            c6   = count6(log_base);
            viol = 0;
            repeat (20) begin
                @(negedge clk);
                if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) viol++;
            end
            check("bp_hold_violations", 32'(viol), 32'd0);
            check("bp_no_cmd6", 32'(count6(log_base) - c6), 32'd0);
            out_ready = 1'b1;
        end
        cyc = 0;
        while (done_cnt == done_base && cyc < 20000) begin @(negedge clk); cyc++; end
        @(negedge clk);
        check("run_done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("run_err_clear", 32'(err), 32'd0);
        check("run_busy_fall", 32'(busy), 32'd0);
        check("run_in_consumed", 32'(src_idx - src_base), 32'(words));
        check("run_out_count", 32'(out_got.size() - out_base), 32'(positions));
        for (int p = 0; p < positions; p++) begin
            if (out_base + p < out_got.size())
                check($sformatf("out_d%0d_p%0d", depth, p), out_got[out_base + p], model(depth, p));
        end
        // Expected non-NOP command stream.
        exp_q.push_back(cmd_t'{cmd: 7'd5, a: 32'd0, d: 32'(depth)});
        exp_q.push_back(cmd_t'{cmd: 7'd8, a: 32'd0, d: 32'd0});
        for (int k = 0; k < 2 * depth; k++) exp_q.push_back(cmd_t'{cmd: 7'd1, a: 32'(4 * k), d: sword(k)});
        exp_q.push_back(cmd_t'{cmd: 7'd6, a: 32'd0, d: 32'd0});
        exp_q.push_back(cmd_t'{cmd: 7'd7, a: 32'd0, d: 32'd0});
        sx = 0;
        wi = 2 * depth;
        for (int p = 1; p < positions; p++) begin
            for (int j = 0; j < depth / 4; j++) begin
                exp_q.push_back(cmd_t'{cmd: 7'd1, a: 32'(sx * depth + 4 * j), d: sword(wi)});
                wi++;
            end
            sx = (sx + 1) % 8;
            exp_q.push_back(cmd_t'{cmd: 7'd8, a: 32'd0, d: 32'(sx)});
            exp_q.push_back(cmd_t'{cmd: 7'd6, a: 32'd0, d: 32'd0});
            exp_q.push_back(cmd_t'{cmd: 7'd7, a: 32'd0, d: 32'd0});
        end
        n = cmd_log.size() - log_base;
        check("cmd_count", 32'(n), 32'(exp_q.size()));
        errs = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            if (cmd_log[log_base + i].cmd !== exp_q[i].cmd) errs++;
            else if (exp_q[i].cmd == 7'd1 &&
                     (cmd_log[log_base + i].a !== exp_q[i].a || cmd_log[log_base + i].d !== exp_q[i].d)) errs++;
            else if ((exp_q[i].cmd == 7'd5 || exp_q[i].cmd == 7'd8) &&
                     cmd_log[log_base + i].d !== exp_q[i].d) errs++;
        end
        check("cmd_seq_errs", 32'(errs), 32'd0);
    endtask

    // ---------------------------------------------------------------- rejected config
    task automatic bad_cfg(input int depth, input int positions);
        int busy_base, en_base, done_base, log_base;
        busy_base = busy_cnt;
        en_base   = eng_en_cnt;
        done_base = done_cnt;
        log_base  = cmd_log.size();
        src_base  = src_idx;
        src_end   = src_idx;
        cfg_depth     = 8'(depth);
        cfg_positions = 16'(positions);
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check($sformatf("bad_d%0d_n%0d_err", depth, positions), 32'(err), 32'd1);
        check($sformatf("bad_d%0d_n%0d_code", depth, positions), 32'(err_code), 32'd1);
        check($sformatf("bad_d%0d_n%0d_busy_cycles", depth, positions), 32'(busy_cnt - busy_base), 32'd1);
        check($sformatf("bad_d%0d_n%0d_done", depth, positions), 32'(done_cnt - done_base), 32'd1);
        check($sformatf("bad_d%0d_n%0d_no_cfu", depth, positions),
              32'(eng_en_cnt - en_base + cmd_log.size() - log_base), 32'd0);
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin
        int cyc, done_base, out_base;
        rst           = 1'b1;
        start         = 1'b0;
        cfg_depth     = 8'd0;
        cfg_positions = 16'd0;
        out_ready     = 1'b1;
        host_en       = 1'b0;
        host_cmd      = 7'd9;
        host_inp0     = 32'd0;
        host_inp1     = 32'd0;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_cfu_en", 32'(cfu_en), 32'd0);
        check("rst_cfu_cmd", 32'(cfu_cmd), 32'd9);
        rst = 1'b0;
        @(negedge clk);

        // Host pass-through while idle.
        host_en   = 1'b1;
        host_cmd  = 7'd3;
        host_inp0 = 32'h12;
        host_inp1 = 32'hFFFF_FF80;
        #1;
        check("host_grant", 32'(host_grant), 32'd1);
        check("host_cfu_en", 32'(cfu_en), 32'd1);
        check("host_cfu_cmd", 32'(cfu_cmd), 32'd3);
        check("host_cfu_inp0", cfu_inp0, 32'h12);
        check("host_cfu_inp1", cfu_inp1, 32'hFFFF_FF80);
        @(negedge clk);
        host_en  = 1'b0;
        host_cmd = 7'd9;
        #1;
        check("host_ret", host_ret, stub_ret);
        @(negedge clk);

        run(4, 1, 1'b0);   // single position
        run(4, 10, 1'b0);  // ring wrap
        run(4, 3, 1'b1);   // output backpressure

        bad_cfg(6, 1);
        bad_cfg(0, 1);
        bad_cfg(132, 1);
        bad_cfg(4, 0);

        // Poll timeout: stand-in never reports ready.
        stub_never = 1'b1;
        done_base  = done_cnt;
        out_base   = out_got.size();
        src_base   = src_idx;
        src_end    = src_idx + 8;
        cfg_depth     = 8'd4;
        cfg_positions = 16'd1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done_cnt == done_base && cyc < 500) begin @(negedge clk); cyc++; end
        check("to_done", 32'(done_cnt - done_base), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_err_code", 32'(err_code), 32'd2);
        check("to_busy", 32'(busy), 32'd0);
        check("to_poll_cycles", 32'(poll_nops), 32'(PollTimeout));
        check("to_no_output", 32'(out_got.size() - out_base), 32'd0);
        stub_never = 1'b0;

        run(8, 3, 1'b0);   // clears err, two-word refills

        // Reset in the middle of preload after three words.
        src_base = src_idx;
        src_end  = src_idx + 3;
        cfg_depth     = 8'd4;
        cfg_positions = 16'd1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while ((src_idx - src_base) < 3 && cyc < 100) begin @(negedge clk); cyc++; end
        check("mid_words_taken", 32'(src_idx - src_base), 32'd3);
        check("mid_in_preload", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_cfu_en", 32'(cfu_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run(4, 2, 1'b0);

        run(128, 2, 1'b0); // maximum depth

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv1d_sequencer.md
Name: conv1d_sequencer

Overview:
- Autonomous controller that drives the conv1d CFU command port (cmd/inp0/inp1/ret) to produce a full row of conv1d outputs without per-step CPU polling.
- Preloads the 8-column input ring buffer from an input word stream, then loops once per output position: start, poll, read, emit, refill, advance start_filter_x.
- Arbitrates the CFU port between this engine and a host pass-through port; the host is used for quant/offset/filter setup while the engine is idle.

Parameters:
- KERNEL_LENGTH, 8, ring buffer columns; must match conv1d.
- MAX_DEPTH, 128, maximum input_depth accepted.
- POLL_TIMEOUT, 4096, cycles in POLL before the run aborts with an error.
- CMD_NOP, 9, idle/poll command (status read, no side effects).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; latches cfg_* and begins a run when idle
- cfg_depth  in  8  input_depth; multiple of 4, range 4..MAX_DEPTH
- cfg_positions  in  16  number of outputs to produce, 1..65535
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at successful run end
- err  out  1  sticky error; cleared by the next accepted start or by rst
- err_code  out  2  1=bad config, 2=poll timeout
- in_data  in  32  4 packed int8 input bytes, byte 0 in [7:0]
- in_valid / in_ready  in / out  1  input stream handshake
- out_data  out  32  quantized result (conv1d ret from cmd 7)
- out_valid / out_ready  out / in  1  output stream handshake
- host_en, host_cmd[7], host_inp0[32], host_inp1[32]  in  host CFU request
- host_grant  out  1  host owns the CFU this cycle (=!busy)
- host_ret  out  32  cfu_ret passthrough
- cfu_en, cfu_cmd[7], cfu_inp0[32], cfu_inp1[32]  out  drive conv1d
- cfu_ret  in  32  conv1d ret (registered in conv1d; valid the cycle after the command)

Behaviour:
- Reset values: state IDLE, busy=0, done=0, err=0, err_code=0, in_ready=0, out_valid=0, out_data=0, cfu_en=0, cfu_cmd=CMD_NOP, cfu_inp0=0, cfu_inp1=0, start_x=0, pos_cnt=0.
- Reset mid-run returns to IDLE immediately. conv1d has no reset and may finish its own computation; the next run's cmd 6 overrides it.
- Mux: when busy=0, cfu_* = host_*. When busy=1, the engine drives cfu_* with cfu_en=1, and host requests are dropped.
- start is ignored while busy. cfg is bad when depth=0, depth[1:0]!=0, depth>MAX_DEPTH, or positions=0. A bad cfg sets err, err_code=1, and a done pulse; busy rises for 1 cycle only.
- States and per-cycle commands:
  - CFG_DEPTH: cmd 5, inp1=depth.
  - CFG_X: cmd 8, inp1=start_x; start_x=0 on the first entry.
  - PRELOAD: consumes 2*depth words. Each accepted word (in_valid&in_ready) issues cmd 1 with inp0=4*k, k=0..2*depth-1. in_ready=1 only in PRELOAD/REFILL. When in_valid=0, issues CMD_NOP.
  - START: cmd 6, 1 cycle.
  - POLL: cmd CMD_NOP every cycle. cfu_ret is ignored in the first POLL cycle (stale). Exit when cfu_ret[0]=1. When the poll counter reaches POLL_TIMEOUT: err, err_code=2, done pulse, go to IDLE.
  - READ: cmd 7, 1 cycle.
  - CAPTURE: CMD_NOP; out_data<=cfu_ret, out_valid<=1.
  - EMIT: holds out_data/out_valid until out_ready. The handshake clears out_valid and increments pos_cnt.
    - If pos_cnt+1==positions: done pulse, go to IDLE.
    - Otherwise go to REFILL.
  - REFILL: consumes depth/4 words; word j issues cmd 1 with inp0=start_x*depth+4*j.
    - Then start_x <= (start_x+1) mod KERNEL_LENGTH, next state CFG_X.
- Arithmetic: addresses are 32-bit unsigned; max 8*128=1024, which fits the conv1d buffer.
- Stream rules:
  - out_data is stable while out_valid=1 && !out_ready.
  - No input is consumed outside PRELOAD/REFILL.
  - The final position does not trigger a refill.
- Throughput: with no stream stalls, the per-position overhead outside POLL is 5 cycles + depth/4.

Test Plan:
- Host pass-through, idle: host_en=1, cmd 3, inp1=-128 -> cfu_cmd=3, cfu_inp1=-128 the same cycle; host_grant=1.
- Single position, depth=4, positions=1: 8 words accepted with cmd 1 addrs 0,4,...,28, preceded by cmd 5 (4) and cmd 8 (0). Then cmd 6, poll, cmd 7. out_data equals the model result. done pulses; no refill occurs.
- Ring wrap, depth=4, positions=10:
  - After each output: 1 refill word at addr start_x*4.
  - cmd 8 values 1..7,0,1 in sequence.
  - All 10 outputs match a golden conv1d model.
- Backpressure: out_ready held 0 for 20 cycles -> out_data stable, in_ready=0, no cmd 6 issued. Releasing out_ready resumes normally.
- Errors:
  - cfg_depth=6 -> err=1, err_code=1, done pulse, no cfu commands issued.
  - POLL_TIMEOUT=16 with a stub CFU whose ret is always 0 -> err_code=2 after 16 poll cycles; busy falls.
- rst asserted during PRELOAD after 3 words -> next cycle: busy=0, in_ready=0, cfu_en=0. A new start reruns from CFG_DEPTH with addr 0.
